cas_loader: RTL and testbench

Upstream stage of the cassette player. Takes the CAS image streamed in by the HPS download interface (ioctl bus), writes it byte-by-byte into SDRAM at a fixed base, and publishes the image length and validity that the playback block uses to locate tape data. While loading, it counts SVI tape blocks by detecting leader-plus-sync sequences, giving the OSD a block count. Backpressure to the HPS is through `ioctl_wait` while an SDRAM write is outstanding.

---
 rtl/cas_loader_if.sv | 28 ++
 rtl/cas_loader.sv | 121 ++++++++++++
 tb/tb_cas_loader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cas_loader_if.sv
// Download (HPS ioctl) and SDRAM write bus of the cassette loader.
// master: the loader side; slave: the host/memory side.
interface cas_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_din;
  logic        sdram_we;
  logic        sdram_ack;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output sdram_addr, sdram_din, sdram_we,
    input  sdram_ack
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  sdram_addr, sdram_din, sdram_we,
    output sdram_ack
  );
endinterface

// File: rtl/cas_loader.sv
// CAS image loader: copies the downloaded cassette image into SDRAM,
// tracks image length/validity and counts leader+sync tape blocks.
module cas_loader #(
  parameter logic [7:0]  CAS_INDEX = 8'd1,
  parameter logic [24:0] BASE_ADDR = 25'h0,
  parameter logic [7:0]  LEAD_BYTE = 8'h55,
  parameter logic [7:0]  SYNC_BYTE = 8'h7F,
  parameter logic [7:0]  LEAD_MIN  = 8'd8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  cas_loader_if.master  bus,
  output logic [24:0]   cas_size_o,
  output logic          cas_valid_o,
  output logic [7:0]    cas_blocks_o
);

  typedef enum logic [1:0] {IDLE, ARMED, WRITE, FINISH} state_e;

  state_e      state_q, state_d;
  logic        active, active_q, rise, accept;
  logic [24:0] end_off;
  logic [24:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [24:0] size_q, size_d;
  logic        valid_q, valid_d;
  logic [7:0]  blocks_q, blocks_d;
  logic [7:0]  lead_q, lead_d;

  assign active  = bus.ioctl_download && (bus.ioctl_index == CAS_INDEX);
  assign rise    = active && !active_q;
  // A byte is only taken while armed and the download is still ours; a
  // strobe during WRITE never reaches here, which discards it.
  assign accept  = (state_q == ARMED) && active && bus.ioctl_wr;
  assign end_off = bus.ioctl_addr + 25'd1;

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (rise) state_d = ARMED;
      ARMED: begin
        if (!active)          state_d = FINISH;
        else if (bus.ioctl_wr) state_d = WRITE;
      end
      // Download end seen during a write is deferred until the ack.
      WRITE:  if (bus.sdram_ack) state_d = active ? ARMED : FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: write request and backpressure span exactly the WRITE state
  always_comb begin
    bus.sdram_we   = (state_q == WRITE);
    bus.ioctl_wait = (state_q == WRITE);
    bus.sdram_addr = addr_q;
    bus.sdram_din  = din_q;
    cas_size_o     = size_q;
    cas_valid_o    = valid_q;
    cas_blocks_o   = blocks_q;
  end

  // Datapath next values: image bookkeeping and block detector
  always_comb begin
    addr_d   = addr_q;
    din_d    = din_q;
    size_d   = size_q;
    valid_d  = valid_q;
    blocks_d = blocks_q;
    lead_d   = lead_q;
    if ((state_q == IDLE) && rise) begin
      size_d   = '0;
      valid_d  = 1'b0;
      blocks_d = '0;
      lead_d   = '0;
    end
    if (accept) begin
      addr_d = BASE_ADDR + bus.ioctl_addr;
      din_d  = bus.ioctl_dout;
      if (end_off > size_q) size_d = end_off;
      if (bus.ioctl_dout == LEAD_BYTE) begin
        if (lead_q != 8'hFF) lead_d = lead_q + 8'd1;
      end else if ((bus.ioctl_dout == SYNC_BYTE) && (lead_q >= LEAD_MIN)) begin
        if (blocks_q != 8'hFF) blocks_d = blocks_q + 8'd1;
        lead_d = '0;
      end else begin
        lead_d = '0;
      end
    end
    if (state_q == FINISH) valid_d = (size_q != '0);
  end

  // Datapath registers and download edge detector
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      size_q   <= '0;
      valid_q  <= 1'b0;
      blocks_q <= '0;
      lead_q   <= '0;
    end else begin
      active_q <= active;
      addr_q   <= addr_d;
      din_q    <= din_d;
      size_q   <= size_d;
      valid_q  <= valid_d;
      blocks_q <= blocks_d;
      lead_q   <= lead_d;
    end
  end

endmodule

// File: tb/tb_cas_loader.sv
// Bench for cas_loader: table vectors, hand sequences and random downloads
// checked against a stream-level model of the image.
module tb_cas_loader;
  localparam logic [24:0] BASE = 25'h0100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] cas_size;
  logic        cas_valid;
  logic [7:0]  cas_blocks;

  always #5 clk = ~clk;

  cas_loader_if bus ();

  cas_loader #(
    .CAS_INDEX (8'd1),
    .BASE_ADDR (BASE),
    .LEAD_BYTE (8'h55),
    .SYNC_BYTE (8'h7F),
    .LEAD_MIN  (8'd8)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .bus          (bus),
    .cas_size_o   (cas_size),
    .cas_valid_o  (cas_valid),
    .cas_blocks_o (cas_blocks)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: the accepted byte stream and the image length
  logic [7:0]  m_bytes[$];
  logic [24:0] m_size;

  typedef struct {
    bit          new_dl;
    logic [24:0] addr;
    logic [7:0]  data;
    int unsigned delay;
    logic [24:0] exp_size;
    logic [7:0]  exp_blocks;
  } vec_t;
  vec_t vt[9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Block = a sync byte preceded by at least 8 consecutive leader bytes
  function automatic logic [7:0] model_blocks();
    int run = 0;
    int blocks = 0;
    foreach (m_bytes[i]) begin
      if (m_bytes[i] == 8'h55) run++;
      else begin
        if (m_bytes[i] == 8'h7F && run >= 8) blocks++;
        run = 0;
      end
    end
    return (blocks > 255) ? 8'd255 : blocks[7:0];
  endfunction

  task automatic dl_start(input logic [7:0] idx);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    tick;
    tick;
    if (idx == 8'd1) begin
      m_bytes.delete();
      m_size = '0;
      chk("start_clear", {cas_valid, cas_blocks, cas_size}, 34'h0);
    end
  endtask

  task automatic dl_end;
    bus.ioctl_download = 1'b0;
    tick;
    chk("valid_f1", cas_valid, 1'b0);
    tick;
    chk("valid_f2", cas_valid, (m_size != 0));
    chk("end_size", cas_size, m_size);
    chk("end_blocks", cas_blocks, model_blocks());
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input int unsigned delay);
    logic [24:0] exp_addr;
    logic [24:0] e;
    exp_addr = BASE + a;
    e = a + 25'd1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    m_bytes.push_back(d);
    if (e > m_size) m_size = e;
    chk("wr_size", cas_size, m_size);
    chk("wr_blocks", cas_blocks, model_blocks());
    for (int unsigned k = 0; k <= delay; k++) begin
      chk("wr_hold", {bus.sdram_we, bus.ioctl_wait, bus.sdram_addr, bus.sdram_din},
          {2'b11, exp_addr, d});
      if (k < delay) tick;
    end
    bus.sdram_ack = 1'b1;
    tick;
    bus.sdram_ack = 1'b0;
    chk("wr_release", {bus.sdram_we, bus.ioctl_wait}, 2'b00);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    logic [24:0] sv_size;
    logic [7:0]  sv_blocks;
    int unsigned a;

    vt[0] = '{1'b1, 25'd0,         8'hAA, 2, 25'd1,         8'd0};
    vt[1] = '{1'b0, 25'd1,         8'hBB, 2, 25'd2,         8'd0};
    vt[2] = '{1'b0, 25'd2,         8'hCC, 2, 25'd3,         8'd0};
    vt[3] = '{1'b0, 25'd3,         8'hDD, 2, 25'd4,         8'd0};
    vt[4] = '{1'b1, 25'd5,         8'h55, 0, 25'd6,         8'd0};
    vt[5] = '{1'b0, 25'd1,         8'h55, 1, 25'd6,         8'd0};
    vt[6] = '{1'b0, 25'd2,         8'h7F, 3, 25'd6,         8'd0};
    vt[7] = '{1'b0, 25'h1FFFFF0,   8'h12, 0, 25'h1FFFFF1,   8'd0};
    vt[8] = '{1'b0, 25'd9,         8'h44, 1, 25'h1FFFFF1,   8'd0};

    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.sdram_ack      = 1'b0;
    m_size = '0;

    // Reset
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("reset_bus", {bus.ioctl_wait, bus.sdram_we, bus.sdram_addr, bus.sdram_din}, 35'h0);
    chk("reset_status", {cas_valid, cas_blocks, cas_size}, 34'h0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      if (vt[i].new_dl) begin
        if (i > 0) dl_end;
        dl_start(8'd1);
      end
      wr_byte(vt[i].addr, vt[i].data, vt[i].delay);
      chk("tbl_size", cas_size, vt[i].exp_size);
      chk("tbl_blocks", cas_blocks, vt[i].exp_blocks);
    end
    dl_end;
    chk("tbl_valid", cas_valid, 1'b1);

    // Block detection: 10x55,7F  3x55,7F  16x55,7F -> 2 blocks
    dl_start(8'd1);
    a = 0;
    for (int i = 0; i < 10; i++) begin wr_byte(a, 8'h55, 0); a++; end
    wr_byte(a, 8'h7F, 0); a++;
    for (int i = 0; i < 3; i++) begin wr_byte(a, 8'h55, 0); a++; end
    wr_byte(a, 8'h7F, 0); a++;
    for (int i = 0; i < 16; i++) begin wr_byte(a, 8'h55, 0); a++; end
    wr_byte(a, 8'h7F, 0); a++;
    chk("blocks_two", cas_blocks, 8'd2);
    dl_end;

    // 300 blocks saturate at 255
    dl_start(8'd1);
    a = 0;
    for (int b = 0; b < 300; b++) begin
      for (int i = 0; i < 8; i++) begin wr_byte(a, 8'h55, 0); a++; end
      wr_byte(a, 8'h7F, 0); a++;
    end
    chk("blocks_sat", cas_blocks, 8'd255);
    chk("sat_size", cas_size, 25'd2700);
    dl_end;

    // Download dropped while a write is pending; stray strobe during WRITE
    dl_start(8'd1);
    wr_byte(25'd0, 8'h11, 1);
    bus.ioctl_addr = 25'd1;
    bus.ioctl_dout = 8'h5A;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    m_bytes.push_back(8'h5A);
    m_size = 25'd2;
    bus.ioctl_addr = 25'h500;
    bus.ioctl_dout = 8'h33;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    chk("stray_din", bus.sdram_din, 8'h5A);
    chk("stray_size", cas_size, 25'd2);
    bus.ioctl_download = 1'b0;
    tick;
    tick;
    chk("defer_we", {bus.sdram_we, bus.ioctl_wait, bus.sdram_addr}, {2'b11, BASE + 25'd1});
    chk("defer_valid", cas_valid, 1'b0);
    bus.sdram_ack = 1'b1;
    tick;
    bus.sdram_ack = 1'b0;
    chk("defer_release", {bus.sdram_we, bus.ioctl_wait}, 2'b00);
    chk("defer_valid_m1", cas_valid, 1'b0);
    tick;
    chk("defer_valid_m2", cas_valid, 1'b1);
    chk("defer_size", cas_size, 25'd2);

    // Foreign index leaves everything untouched
    sv_size   = cas_size;
    sv_blocks = cas_blocks;
    dl_start(8'd2);
    bus.ioctl_addr = 25'd7;
    bus.ioctl_dout = 8'h99;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    chk("idx2_we", {bus.sdram_we, bus.ioctl_wait}, 2'b00);
    bus.ioctl_download = 1'b0;
    tick;
    tick;
    tick;
    chk("idx2_status", {cas_valid, cas_blocks, cas_size}, {1'b1, sv_blocks, sv_size});

    // Zero-byte download invalidates the previous image
    dl_start(8'd1);
    dl_end;
    chk("empty_valid", cas_valid, 1'b0);

    // Reset during WRITE, then a stale ack
    dl_start(8'd1);
    bus.ioctl_addr = 25'd4;
    bus.ioctl_dout = 8'h77;
    bus.ioctl_wr   = 1'b1;
    tick;
    bus.ioctl_wr = 1'b0;
    chk("rst_pre_we", bus.sdram_we, 1'b1);
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick;
    reset = 1'b0;
    chk("rst_bus", {bus.ioctl_wait, bus.sdram_we, bus.sdram_addr, bus.sdram_din}, 35'h0);
    chk("rst_status", {cas_valid, cas_blocks, cas_size}, 34'h0);
    bus.sdram_ack = 1'b1;
    tick;
    bus.sdram_ack = 1'b0;
    tick;
    chk("stale_ack", {bus.ioctl_wait, bus.sdram_we, cas_valid, cas_size}, 28'h0);
    dl_start(8'd1);
    wr_byte(25'd0, 8'h21, 1);
    dl_end;

    // Random downloads against the model
    for (int d = 0; d < 6; d++) begin
      int unsigned n;
      dl_start(8'd1);
      n = $urandom_range(5, 40);
      for (int unsigned i = 0; i < n; i++) begin
        logic [24:0] ra;
        logic [7:0]  rd;
        int unsigned r;
        ra = ($urandom_range(0, 3) == 0) ? 25'($urandom_range(0, 99)) : 25'(i);
        r  = $urandom_range(0, 9);
        rd = (r < 6) ? 8'h55 : (r < 8) ? 8'h7F : 8'($urandom);
        wr_byte(ra, rd, $urandom_range(0, 3));
      end
      dl_end;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
